// File: rtl/alarm_time_keeper.sv
// Alarm clock time keeper: HH:MM:SS counter advanced by a 1 Hz tick, alarm register and alarm FSM.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_time_keeper #(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_time,
    input  logic       set_alarm,
    input  logic [4:0] hh_in,
    input  logic [5:0] mm_in,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hr_out,
    output logic       ringing,
    output logic       day_wrap
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2
`ifdef ALARM_SNOOZE_EN
        , S_SNOOZE = 2'd3
`endif
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hr_q, hr_d;
    logic [4:0] alarm_hr_q, alarm_hr_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic       day_wrap_q, day_wrap_d;
    logic       ringing_q, ringing_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    state_t     state_q, state_d;
    logic       load_ok, new_time, new_alarm, tick_adv, alarm_hit;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_MIN * 60 - 1);
    logic [9:0] snooze_cnt_q, snooze_cnt_d;
`else
    localparam int unsigned snooze_min_unused = SNOOZE_MIN;
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    // Time and alarm registers; a valid set_time swallows a coincident tick.
    always_comb begin
        load_ok     = (hh_in <= 5'd23) && (mm_in <= 6'd59);
        new_time    = set_time && load_ok;
        new_alarm   = set_alarm && load_ok;
        tick_adv    = tick && !new_time;
        sec_d       = sec_q;
        min_d       = min_q;
        hr_d        = hr_q;
        day_wrap_d  = 1'b0;
        alarm_hr_d  = alarm_hr_q;
        alarm_min_d = alarm_min_q;
        if (new_time) begin
            hr_d  = hh_in;
            min_d = mm_in;
            sec_d = '0;
        end else if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d = '0;
                    if (hr_q == 5'd23) begin
                        hr_d       = '0;
                        day_wrap_d = 1'b1;
                    end else begin
                        hr_d = hr_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        if (new_alarm) begin
            alarm_hr_d  = hh_in;
            alarm_min_d = mm_in;
        end
    end

    // Alarm FSM: match is taken on the advanced time, so a set_time onto the alarm never fires.
    always_comb begin
        alarm_hit  = tick_adv && (sec_d == 6'd0) && (min_d == alarm_min_q) && (hr_d == alarm_hr_q);
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif
        case (state_q)
            S_IDLE:  state_d = S_ARMED;
            S_ARMED: if (alarm_hit) state_d = S_RINGING;
            S_RINGING: begin
                if (new_alarm || stop) begin
                    state_d = S_ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_d = S_SNOOZE;
`endif
                end else if (tick) begin
                    if (ring_cnt_q == RING_LAST) state_d = S_ARMED;
                    else ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (new_alarm || stop) begin
                    state_d = S_ARMED;
                end else if (tick) begin
                    if (snooze_cnt_q == SNOOZE_LAST) state_d = S_RINGING;
                    else snooze_cnt_d = snooze_cnt_q + 10'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (!alarm_en) state_d = S_IDLE;
        if (state_d != state_q) begin
            ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = '0;
`endif
        end
        ringing_d = (state_d == S_RINGING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            day_wrap_q  <= 1'b0;
            ringing_q   <= 1'b0;
            ring_cnt_q  <= '0;
            state_q     <= S_IDLE;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            alarm_hr_q  <= alarm_hr_d;
            alarm_min_q <= alarm_min_d;
            day_wrap_q  <= day_wrap_d;
            ringing_q   <= ringing_d;
            ring_cnt_q  <= ring_cnt_d;
            state_q     <= state_d;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    assign sec_out  = sec_q;
    assign min_out  = min_q;
    assign hr_out   = hr_q;
    assign ringing  = ringing_q;
    assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Directed bench for alarm_time_keeper: vector table plus multi-cycle alarm, wrap and reset sequences.
module tb_alarm_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, set_time = 1'b0, set_alarm = 1'b0;
    logic [4:0] hh_in = '0;
    logic [5:0] mm_in = '0;
    logic       alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic [5:0] sec_out, min_out;
    logic [4:0] hr_out;
    logic       ringing, day_wrap;

    int n_vec = 0;
    int n_bad = 0;

    alarm_time_keeper #(.RING_SECS(60), .SNOOZE_MIN(5)) dut (
        .clk(clk), .rst(rst), .tick(tick), .set_time(set_time), .set_alarm(set_alarm),
        .hh_in(hh_in), .mm_in(mm_in), .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
        .sec_out(sec_out), .min_out(min_out), .hr_out(hr_out), .ringing(ringing), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    st, sa, tk;
        int    hh, mm;
        int    eh, em, es;
        bit    er, ew;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, int eh, int em, int es, bit er, bit ew);
        n_vec++;
        if (hr_out !== 5'(eh) || min_out !== 6'(em) || sec_out !== 6'(es) ||
            ringing !== er || day_wrap !== ew) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d ring=%b wrap=%b, expected %0d:%0d:%0d ring=%b wrap=%b",
                     name, hr_out, min_out, sec_out, ringing, day_wrap, eh, em, es, er, ew);
        end
    endtask

    task automatic cyc(bit st, bit sa, bit tk, bit sp, bit sz, int hh, int mm);
        set_time  = st;
        set_alarm = sa;
        tick      = tk;
        stop      = sp;
        snooze    = sz;
        hh_in     = 5'(hh);
        mm_in     = 6'(mm);
        @(posedge clk);
        #1;
        set_time = 1'b0; set_alarm = 1'b0; tick = 1'b0; stop = 1'b0; snooze = 1'b0;
    endtask

    // Ticks separated by an idle cycle; returns just after the last tick edge.
    task automatic do_ticks(int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc(0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        vecs.push_back('{"idle",          0, 0, 0,  0,  0, 0,  0,  0, 0, 0});
        vecs.push_back('{"tick0",         0, 0, 1,  0,  0, 0,  0,  1, 0, 0});
        vecs.push_back('{"set_10_20",     1, 0, 0, 10, 20, 10, 20, 0, 0, 0});
        vecs.push_back('{"tick1",         0, 0, 1,  0,  0, 10, 20, 1, 0, 0});
        vecs.push_back('{"set_bad_hr",    1, 0, 0, 25, 10, 10, 20, 1, 0, 0});
        vecs.push_back('{"set_bad_min",   1, 0, 0, 12, 60, 10, 20, 1, 0, 0});
        vecs.push_back('{"set_with_tick", 1, 0, 1, 12,  0, 12,  0, 0, 0, 0});
        vecs.push_back('{"tick2",         0, 0, 1,  0,  0, 12,  0, 1, 0, 0});
        vecs.push_back('{"both_bad",      1, 1, 0, 24,  0, 12,  0, 1, 0, 0});
        vecs.push_back('{"both_10_59",    1, 1, 0, 10, 59, 10, 59, 0, 0, 0});
        vecs.push_back('{"tick3",         0, 0, 1,  0,  0, 10, 59, 1, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].st, vecs[i].sa, vecs[i].tk, 0, 0, vecs[i].hh, vecs[i].mm);
            check(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ew);
        end

        // minute and hour carry
        do_ticks(59);
        check("hour_carry", 11, 0, 0, 0, 0);

        // day wrap
        cyc(1, 0, 0, 0, 0, 23, 59);
        do_ticks(59);
        check("pre_wrap", 23, 59, 59, 0, 0);
        do_ticks(1);
        check("wrap", 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("wrap_one_cycle", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("set_midnight_no_wrap", 0, 0, 0, 0, 0);

        // alarm rings for RING_SECS ticks
        alarm_en = 1'b1;
        cyc(0, 1, 0, 0, 0, 7, 30);
        cyc(1, 0, 0, 0, 0, 7, 29);
        do_ticks(59);
        check("pre_alarm", 7, 29, 59, 0, 0);
        do_ticks(1);
        check("alarm_rise", 7, 30, 0, 1, 0);
        do_ticks(59);
        check("still_ringing", 7, 30, 59, 1, 0);
        do_ticks(1);
        check("ring_timeout", 7, 31, 0, 0, 0);

        // set_alarm while ringing returns to ARMED
        cyc(1, 0, 0, 0, 0, 7, 29);
        do_ticks(60);
        check("alarm_rise2", 7, 30, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 8, 0);
        check("set_alarm_silences", 7, 30, 0, 0, 0);

        // stop, and set_time onto alarm does not fire
        cyc(1, 0, 0, 0, 0, 7, 59);
        do_ticks(60);
        check("alarm_rise3", 8, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("stop", 8, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 8, 0);
        check("set_onto_alarm", 8, 0, 0, 0, 0);

        cyc(1, 0, 0, 0, 0, 7, 59);
        do_ticks(60);
        check("alarm_rise4", 8, 0, 0, 1, 0);
`ifndef ALARM_SNOOZE_EN
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("snooze_ignored", 8, 0, 0, 1, 0);
`endif
        do_ticks(5);
        check("ring_8_00_05", 8, 0, 5, 1, 0);

        // asynchronous reset mid-ring
        #2 rst = 1'b1;
        #1 check("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("post_reset", 0, 0, 0, 0, 0);
        do_ticks(5);
        check("post_reset_ticks", 0, 0, 5, 0, 0);

        // alarm disabled
        alarm_en = 1'b0;
        cyc(1, 1, 0, 0, 0, 8, 59);
        cyc(0, 1, 0, 0, 0, 9, 0);
        do_ticks(60);
        check("disabled_no_ring", 9, 0, 0, 0, 0);
        alarm_en = 1'b1;

`ifdef ALARM_SNOOZE_EN
        cyc(0, 1, 0, 0, 0, 6, 0);
        cyc(1, 0, 0, 0, 0, 5, 59);
        do_ticks(60);
        check("snz_rise", 6, 0, 0, 1, 0);
        do_ticks(10);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("snooze_low", 6, 0, 10, 0, 0);
        do_ticks(299);
        check("snooze_wait", 6, 5, 9, 0, 0);
        do_ticks(1);
        check("snooze_rering", 6, 5, 10, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        check("stop_wins", 6, 5, 10, 0, 0);
        do_ticks(300);
        check("no_rering", 6, 10, 10, 0, 0);
        cyc(1, 0, 0, 0, 0, 5, 59);
        do_ticks(60);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        do_ticks(300);
        check("stop_in_snooze", 6, 5, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
